uart_tx_unit: RTL and testbench

UART transmitter for the same frame format the receive path decodes. A parallel word is accepted on a single-cycle strobe and serialized LSB-first on `data_tx` as start bit, data, optional parity and stop bit(s). The block contains its own baud-tick divider driven by the same `baud_rate` select as the receive path. It sits beside the receiver in the UART core, and its `data_tx` output drives the line that a receiver's `data_tx` input samples.

---
 rtl/uart_tx_unit.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s), with its own baud divider.
// Define UART_TX_HOLD_REG_EN to add a one-entry holding register for gapless back-to-back frames.
module uart_tx_unit #(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1,
  parameter int CLK_FREQ  = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_type,
  input  logic [1:0]           baud_rate,
  output logic                 data_tx,
  output logic                 ready,
  output logic                 active_flag,
  output logic                 done_flag
);

  localparam int DIV_2400  = CLK_FREQ / 2400;
  localparam int DIV_4800  = CLK_FREQ / 4800;
  localparam int DIV_9600  = CLK_FREQ / 9600;
  localparam int DIV_19200 = CLK_FREQ / 19200;
  localparam int CNT_W     = (DIV_2400 > 1) ? $clog2(DIV_2400) : 1;
  localparam int BIT_W     = $clog2(DATA_BITS + STOP_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     div_last;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] next_shift;
  logic [DATA_BITS-1:0] launch_data;
  logic [1:0]           launch_parity;
  logic [1:0]           launch_baud;
  logic                 parity_bit;
  logic                 accept;
  logic                 bit_end;
  logic                 frame_end;
  logic                 launch;

  // The counter runs 0..DIV-1, so the last count of a bit is DIV-1.
  function automatic logic [CNT_W-1:0] div_last_for(input logic [1:0] sel);
    case (sel)
      2'b00:   div_last_for = CNT_W'(DIV_2400 - 1);
      2'b01:   div_last_for = CNT_W'(DIV_4800 - 1);
      2'b10:   div_last_for = CNT_W'(DIV_9600 - 1);
      default: div_last_for = CNT_W'(DIV_19200 - 1);
    endcase
  endfunction

  function automatic logic parity_for(input logic [DATA_BITS-1:0] d, input logic [1:0] pt);
    case (pt)
      2'b10:   parity_for = ^d;
      2'b01:   parity_for = ~^d;
      default: parity_for = 1'b1;
    endcase
  endfunction

  assign accept     = send & ready;
  assign bit_end    = (baud_cnt == div_last);
  assign frame_end  = (state == STOP) && bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign next_shift = shift >> 1;

`ifdef UART_TX_HOLD_REG_EN
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;
  logic [1:0]           hold_parity;
  logic [1:0]           hold_baud;

  // A held word always launches at frame end; otherwise a fresh word launches when the shifter frees up.
  assign ready         = ~hold_valid;
  assign launch        = hold_valid ? frame_end : (accept && ((state == IDLE) || frame_end));
  assign launch_data   = hold_valid ? hold_data : data_in;
  assign launch_parity = hold_valid ? hold_parity : parity_type;
  assign launch_baud   = hold_valid ? hold_baud : baud_rate;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      hold_parity <= '0;
      hold_baud   <= '0;
    end else if (launch && hold_valid) begin
      hold_valid <= 1'b0;
    end else if (accept && !launch) begin
      hold_valid  <= 1'b1;
      hold_data   <= data_in;
      hold_parity <= parity_type;
      hold_baud   <= baud_rate;
    end
  end
`else
  assign ready         = ~active_flag;
  assign launch        = accept;
  assign launch_data   = data_in;
  assign launch_parity = parity_type;
  assign launch_baud   = baud_rate;
`endif

  // Frame sequencer; a launch overrides the frame-end return to IDLE so frames can chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      div_last    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
      end
      case (state)
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            data_tx <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= next_shift;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state   <= PARITY;
                data_tx <= parity_bit;
              end else begin
                state   <= STOP;
                data_tx <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              data_tx <= next_shift[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            bit_cnt <= '0;
            data_tx <= 1'b1;
          end
        end
        STOP: begin
          if (frame_end) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            active_flag <= 1'b0;
            done_flag   <= 1'b1;
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        default: ;
      endcase
      if (launch) begin
        state       <= START;
        baud_cnt    <= '0;
        bit_cnt     <= '0;
        div_last    <= div_last_for(launch_baud);
        shift       <= launch_data;
        parity_bit  <= parity_for(launch_data, launch_parity);
        data_tx     <= 1'b0;
        active_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Testbench for uart_tx_unit: per-clock line levels compared against a frame model built from the framing rules.
// Also covers the UART_TX_HOLD_REG_EN build when that macro is defined.
module tb_uart_tx_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       data_tx;
  logic       ready;
  logic       active_flag;
  logic       done_flag;

  int errors = 0;
  int checks = 0;
  bit expLine[$];

`ifdef UART_TX_HOLD_REG_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  uart_tx_unit #(
    .DATA_BITS(8),
    .PARITY_EN(1),
    .STOP_BITS(1),
    .CLK_FREQ(96000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .send(send),
    .data_in(data_in),
    .parity_type(parity_type),
    .baud_rate(baud_rate),
    .data_tx(data_tx),
    .ready(ready),
    .active_flag(active_flag),
    .done_flag(done_flag)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic int divFor(input logic [1:0] br);
    return 96000 / (2400 * (1 << br));
  endfunction

  // Appends one frame's line level for every clock it occupies.
  task automatic addFrame(input logic [7:0] data, input logic [1:0] pt, input logic [1:0] br);
    int d = divFor(br);
    int ones = $countones(data);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pt == 2'b10)      bits.push_back(ones % 2 == 1);
    else if (pt == 2'b01) bits.push_back(ones % 2 == 0);
    else                  bits.push_back(1'b1);
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (d) expLine.push_back(bits[i]);
  endtask

  task automatic sendWord(input logic [7:0] data, input logic [1:0] pt, input logic [1:0] br);
    data_in     = data;
    parity_type = pt;
    baud_rate   = br;
    send        = 1'b1;
    @(posedge clock); #1;
    send = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] pt, input logic [1:0] br,
                               input int disturbAt);
    expLine.delete();
    addFrame(data, pt, br);
    sendWord(data, pt, br);
    for (int c = 1; c <= expLine.size(); c++) begin
      checkOutput($sformatf("line d%0h c%0d", data, c), data_tx, expLine[c-1]);
      if (c == 1) begin
        checkOutput("active_on", active_flag, 1);
        checkOutput("ready_busy", ready, HOLD ? 1 : 0);
      end
      if (c == 2) checkOutput("done_mid", done_flag, 0);
      if (c == disturbAt) begin
        baud_rate   = ~br;
        parity_type = ~pt;
        data_in     = ~data;
        if (!HOLD) send = 1'b1;
      end
      if (c == disturbAt + 1) send = 1'b0;
      @(posedge clock); #1;
    end
    send = 1'b0;
    checkOutput("done_pulse", done_flag, 1);
    checkOutput("active_off", active_flag, 0);
    checkOutput("ready_back", ready, 1);
    checkOutput("line_idle_end", data_tx, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      checkOutput("done_cleared", done_flag, 0);
      checkOutput("line_stays_idle", data_tx, 1);
      checkOutput("no_second_frame", active_flag, 0);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    send        = 1'b0;
    data_in     = '0;
    parity_type = '0;
    baud_rate   = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_line", data_tx, 1);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_active", active_flag, 0);
    checkOutput("rst_done", done_flag, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("idle_line", data_tx, 1);
    checkOutput("idle_ready", ready, 1);

    // Fast even-parity frame, then slow odd-parity frame disturbed mid-frame.
    applyStimulus(8'hA5, 2'b10, 2'b11, 0);
    applyStimulus(8'hA5, 2'b01, 2'b00, 20);

    // Asynchronous reset in the middle of a frame.
    sendWord(8'h3C, 2'b10, 2'b11);
    repeat (22) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_line", data_tx, 1);
    checkOutput("midrst_active", active_flag, 0);
    checkOutput("midrst_ready", ready, 1);
    checkOutput("midrst_done", done_flag, 0);
    #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("postrst_idle", data_tx, 1);
    applyStimulus(8'h3C, 2'b10, 2'b11, 0);

    for (int n = 0; n < 4; n++) begin
      applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(2, 30)));
    end

`ifdef UART_TX_HOLD_REG_EN
    // Second word queued while the first is shifting must follow with no idle gap.
    expLine.delete();
    addFrame(8'h01, 2'b10, 2'b11);
    addFrame(8'hFF, 2'b01, 2'b11);
    sendWord(8'h01, 2'b10, 2'b11);
    for (int c = 1; c <= expLine.size(); c++) begin
      checkOutput($sformatf("hold_line c%0d", c), data_tx, expLine[c-1]);
      checkOutput($sformatf("hold_done c%0d", c), done_flag, (c == 56) ? 1 : 0);
      if (c == 3) begin
        data_in     = 8'hFF;
        parity_type = 2'b01;
        baud_rate   = 2'b11;
        send        = 1'b1;
      end
      if (c == 4) send = 1'b0;
      if (c == 10) checkOutput("hold_full_ready", ready, 0);
      if (c == 56) checkOutput("hold_active_kept", active_flag, 1);
      @(posedge clock); #1;
    end
    checkOutput("hold_done_last", done_flag, 1);
    checkOutput("hold_active_off", active_flag, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
